// File: rtl/adc_tx_pkg.sv
// ============================================================================
// Module      : adc_tx_pkg
// Description : Shared constants and FSM encoding for the ADC frame transmitter.
//               Optional macro ADC_FRAME_CHECKSUM_EN selects the 6-byte frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_tx_pkg;

    localparam logic [7:0] c_HEADER = 8'hA5;

`ifdef ADC_FRAME_CHECKSUM_EN
    localparam int unsigned c_FRAME_BYTES = 6;
`else
    localparam int unsigned c_FRAME_BYTES = 5;
`endif

    // start + 8 data + stop
    localparam int unsigned c_UART_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_byte.sv
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer, LSB first, BAUD_DIV clocks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_byte
    import adc_tx_pkg::*;
#(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int              c_CW        = $clog2(BAUD_DIV);
    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(BAUD_DIV - 1);
    localparam logic [3:0]      c_LAST_BIT  = 4'(c_UART_BITS - 1);

    logic            r_busy;
    logic [c_CW-1:0] r_baud;
    logic [3:0]      r_bit;
    logic [8:0]      r_shift;
    logic            r_tx;
    logic            w_bit_end;
    logic            w_last;
    logic            w_accept;

    assign w_bit_end = (r_baud == c_BAUD_LAST);
    // Ready during the final stop-bit cycle so the next start bit follows with no gap.
    assign w_last    = r_busy && w_bit_end && (r_bit == c_LAST_BIT);
    assign ready_o   = !r_busy || w_last;
    assign w_accept  = valid_i && ready_o;
    assign tx_o      = r_tx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy  <= 1'b0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_tx    <= 1'b1;
        end else if (w_accept) begin
            r_busy  <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= {1'b1, data_i};
            r_tx    <= 1'b0;
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == c_LAST_BIT) begin
                    r_busy <= 1'b0;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bit   <= r_bit + 4'd1;
                end
            end else begin
                r_baud <= r_baud + c_CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_frame_tx.sv
// ============================================================================
// Module      : adc_frame_tx
// Description : Latches a two-channel ADC pair and sends header + data bytes
//               as 8N1 UART. ADC_FRAME_CHECKSUM_EN appends an XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_frame_tx
    import adc_tx_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int BAUD_DIV = 868
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] ch1_i,
    input  logic [DATA_W-1:0] ch2_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              ovr_o
);

    localparam logic [2:0] c_LAST_IDX = 3'(c_FRAME_BYTES - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_idx;
    logic [DATA_W-1:0] r_ch1;
    logic [DATA_W-1:0] r_ch2;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        w_byte;
    logic              w_valid;
    logic              w_ready;
    logic              w_accept;
    logic [7:0]        w_ch1_hi;
    logic [7:0]        w_ch2_hi;

    // Upper bits above [7:0] are zero-extended into the hi byte.
    assign w_ch1_hi = 8'(r_ch1 >> 8);
    assign w_ch2_hi = 8'(r_ch2 >> 8);
    assign w_accept = w_valid && w_ready;

`ifdef ADC_FRAME_CHECKSUM_EN
    logic [7:0] r_csum;
`endif

    always_comb begin
        w_byte = c_HEADER;
        case (r_idx)
            3'd1:    w_byte = w_ch1_hi;
            3'd2:    w_byte = r_ch1[7:0];
            3'd3:    w_byte = w_ch2_hi;
            3'd4:    w_byte = r_ch2[7:0];
`ifdef ADC_FRAME_CHECKSUM_EN
            3'd5:    w_byte = r_csum;
`endif
            default: w_byte = c_HEADER;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_nxt = ST_SEND;
            ST_SEND: begin
                w_valid = 1'b1;
                if (w_accept && (r_idx == c_LAST_IDX)) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: if (w_ready) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx  <= '0;
            r_ch1  <= '0;
            r_ch2  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
            r_csum <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (start_i) begin
                    r_ch1  <= ch1_i;
                    r_ch2  <= ch2_i;
                    r_idx  <= '0;
                    r_busy <= 1'b1;
`ifdef ADC_FRAME_CHECKSUM_EN
                    r_csum <= '0;
`endif
                end
                ST_SEND: if (w_accept) begin
                    r_idx  <= r_idx + 3'd1;
`ifdef ADC_FRAME_CHECKSUM_EN
                    r_csum <= r_csum ^ w_byte;
`endif
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .data_i  (w_byte),
        .valid_i (w_valid),
        .ready_o (w_ready),
        .tx_o    (tx_o)
    );

    assign busy_o = r_busy;
    assign done_o = r_done;
    assign ovr_o  = start_i && r_busy;

endmodule

`default_nettype wire

// File: tb/tb_adc_frame_tx.sv
// ============================================================================
// Module      : tb_adc_frame_tx
// Description : Directed bench for adc_frame_tx (12-bit and 16-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_frame_tx;

    localparam int B = 4;
`ifdef ADC_FRAME_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct {
        logic [15:0]     c1;
        logic [15:0]     c2;
        logic [4:0][7:0] eb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [11:0] ch1_a = '0, ch2_a = '0;
    logic [15:0] ch1_b = '0, ch2_b = '0;
    logic        tx_a, busy_a, done_a, ovr_a;
    logic        tx_b, busy_b, done_b, ovr_b;

    int cyc = 0;
    int n_pass = 0, n_tot = 0;
    int done_cnt_a = 0, done_cnt_b = 0;
    int last_done_a = -1, last_done_b = -1;
    vec_t vec [4];

    adc_frame_tx #(.DATA_W(12), .BAUD_DIV(B)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .ch1_i(ch1_a), .ch2_i(ch2_a),
        .tx_o(tx_a), .busy_o(busy_a), .done_o(done_a), .ovr_o(ovr_a));

    adc_frame_tx #(.DATA_W(16), .BAUD_DIV(B)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .ch1_i(ch1_b), .ch2_i(ch2_b),
        .tx_o(tx_b), .busy_o(busy_b), .done_o(done_b), .ovr_o(ovr_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_a === 1'b1) begin done_cnt_a <= done_cnt_a + 1; last_done_a <= cyc; end
        if (done_b === 1'b1) begin done_cnt_b <= done_cnt_b + 1; last_done_b <= cyc; end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic tx_of(input int sel);   return (sel == 1) ? tx_b   : tx_a;   endfunction
    function automatic logic busy_of(input int sel); return (sel == 1) ? busy_b : busy_a; endfunction
    function automatic logic done_of(input int sel); return (sel == 1) ? done_b : done_a; endfunction
    function automatic logic ovr_of(input int sel);  return (sel == 1) ? ovr_b  : ovr_a;  endfunction
    function automatic int dcnt(input int sel);      return (sel == 1) ? done_cnt_b  : done_cnt_a;  endfunction
    function automatic int dlast(input int sel);     return (sel == 1) ? last_done_b : last_done_a; endfunction

    function automatic vec_t mk(input logic [15:0] c1, input logic [15:0] c2,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input logic [7:0] b3, input logic [7:0] b4);
        vec_t v;
        v.c1 = c1; v.c2 = c2;
        v.eb[0] = b0; v.eb[1] = b1; v.eb[2] = b2; v.eb[3] = b3; v.eb[4] = b4;
        return v;
    endfunction

    function automatic logic [5:0][7:0] expand(input logic [4:0][7:0] eb);
        logic [5:0][7:0] e;
        e = '0;
        for (int i = 0; i < 5; i++) begin
            e[i] = eb[i];
            e[5] = e[5] ^ eb[i];
        end
        return e;
    endfunction

    task automatic drive(input int sel, input logic st, input logic [15:0] c1, input logic [15:0] c2);
        if (sel == 1) begin start_b = st; ch1_b = c1; ch2_b = c2; end
        else begin start_a = st; ch1_a = c1[11:0]; ch2_a = c2[11:0]; end
    endtask

    // Samples every cycle of each 10-bit character; shape requires every bit to be flat for B cycles.
    task automatic rx_frame(input int sel, output logic [5:0][7:0] got, output logic [5:0] shape,
                            output int first, output bit busy_all);
        logic s [10*B];
        int   n;
        bit   ok;
        logic v;
        got = '0; shape = '0; busy_all = 1'b1; first = -1; n = 0;
        while (tx_of(sel) !== 1'b0 && n < 40) begin tick(); n++; end
        chk("rx_start_found", {31'b0, tx_of(sel)}, 32'd0);
        if (tx_of(sel) !== 1'b0) return;
        first = cyc;
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < 10*B; c++) begin
                if (b != 0 || c != 0) tick();
                s[c] = tx_of(sel);
                if (busy_of(sel) !== 1'b1) busy_all = 1'b0;
            end
            ok = 1'b1;
            for (int c = 0; c < B; c++) if (s[c] !== 1'b0) ok = 1'b0;
            for (int c = 9*B; c < 10*B; c++) if (s[c] !== 1'b1) ok = 1'b0;
            for (int j = 0; j < 8; j++) begin
                v = s[(j+1)*B];
                for (int t = 0; t < B; t++) if (s[(j+1)*B+t] !== v) ok = 1'b0;
                got[b][j] = v;
            end
            shape[b] = ok;
        end
    endtask

    task automatic run_vec(input int sel, input vec_t vv, input int ovr_at, input string name);
        logic [5:0][7:0] e, got;
        logic [5:0]      shape;
        int              k, d0, first, n;
        bit              busy_all;
        e = expand(vv.eb);
        tick();
        drive(sel, 1'b1, vv.c1, vv.c2);
        k  = cyc + 1;
        d0 = dcnt(sel);
        tick();
        drive(sel, 1'b0, vv.c1, vv.c2);
        chk({name, "_busy_rise"}, {31'b0, busy_of(sel)}, 32'd1);
        fork
            rx_frame(sel, got, shape, first, busy_all);
            begin
                if (ovr_at > 0) begin
                    repeat (ovr_at) tick();
                    drive(sel, 1'b1, ~vv.c1, ~vv.c2);
                    #1 chk({name, "_ovr_pulse"}, {31'b0, ovr_of(sel)}, 32'd1);
                    tick();
                    drive(sel, 1'b0, ~vv.c1, ~vv.c2);
                    #1 chk({name, "_ovr_clear"}, {31'b0, ovr_of(sel)}, 32'd0);
                end
            end
        join
        chk({name, "_first_start"}, first, k + 1);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_byte%0d", name, b), {24'b0, got[b]}, {24'b0, e[b]});
            chk($sformatf("%s_shape%0d", name, b), {31'b0, shape[b]}, 32'd1);
        end
        chk({name, "_busy_held"}, {31'b0, busy_all}, 32'd1);
        n = 0;
        while (dcnt(sel) == d0 && n < 20) begin tick(); n++; end
        chk({name, "_done_latency"}, dlast(sel) - k, NB*10*B + 2);
        tick();
        chk({name, "_done_once"}, dcnt(sel) - d0, 1);
        chk({name, "_busy_fall"}, {31'b0, busy_of(sel)}, 32'd0);
    endtask

    logic [5:0][7:0] h_got;
    logic [5:0]      h_shape;
    int              h_first [3];
    bit              h_busy;
    int              k, dc, n;
    bit              txbad;
    logic [5:0][7:0] ee;

    initial begin
        vec[0] = mk(16'h0ABC, 16'h0123, 8'hA5, 8'h0A, 8'hBC, 8'h01, 8'h23);
        vec[1] = mk(16'h0FFF, 16'h0000, 8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h00);
        vec[2] = mk(16'h0000, 16'h0FFF, 8'hA5, 8'h00, 8'h00, 8'h0F, 8'hFF);
        vec[3] = mk(16'h05A5, 16'h0A5A, 8'hA5, 8'h05, 8'hA5, 8'h0A, 8'h5A);

        // Reset values
        tick(); tick();
        chk("rst_tx",   {31'b0, tx_a},   32'd1);
        chk("rst_busy", {31'b0, busy_a}, 32'd0);
        chk("rst_done", {31'b0, done_a}, 32'd0);
        chk("rst_ovr",  {31'b0, ovr_a},  32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_tx", {31'b0, tx_a}, 32'd1);

        for (int i = 0; i < 4; i++) run_vec(0, vec[i], 0, $sformatf("vec%0d", i));

        // Overrun during byte 2; frame must carry the originally latched data.
        run_vec(0, vec[0], 20*B + 5, "ovr");

        // start_i in the DONE cycle is ignored and flags overrun.
        tick();
        drive(0, 1'b1, vec[3].c1, vec[3].c2);
        k = cyc + 1;
        tick();
        drive(0, 1'b0, vec[3].c1, vec[3].c2);
        n = 0;
        while (cyc < k + NB*10*B + 1 && n < 400) begin tick(); n++; end
        chk("donecyc_busy", {31'b0, busy_a}, 32'd1);
        chk("donecyc_done", {31'b0, done_a}, 32'd0);
        drive(0, 1'b1, vec[1].c1, vec[1].c2);
        #1 chk("donecyc_ovr", {31'b0, ovr_a}, 32'd1);
        tick();
        drive(0, 1'b0, vec[1].c1, vec[1].c2);
        chk("donecyc_done_hi", {31'b0, done_a}, 32'd1);
        chk("donecyc_busy_lo", {31'b0, busy_a}, 32'd0);
        tick();
        chk("donecyc_not_accepted", {31'b0, busy_a}, 32'd0);

        // start_i held high across three frames with data changing after each accept.
        tick();
        drive(0, 1'b1, vec[1].c1, vec[1].c2);
        k  = cyc + 1;
        dc = done_cnt_a;
        fork
            begin
                tick();
                drive(0, 1'b1, vec[2].c1, vec[2].c2);
                for (int f = 0; f < 3; f++) begin
                    n = 0;
                    while (done_a !== 1'b1 && n < 400) begin tick(); n++; end
                    if (f == 2) drive(0, 1'b0, vec[0].c1, vec[0].c2);
                    else begin
                        tick();
                        if (f == 0) drive(0, 1'b1, vec[3].c1, vec[3].c2);
                        else        drive(0, 1'b1, vec[0].c1, vec[0].c2);
                    end
                end
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    rx_frame(0, h_got, h_shape, h_first[f], h_busy);
                    ee = expand(vec[f+1].eb);
                    for (int b = 0; b < NB; b++) begin
                        chk($sformatf("held%0d_byte%0d", f, b), {24'b0, h_got[b]}, {24'b0, ee[b]});
                        chk($sformatf("held%0d_shape%0d", f, b), {31'b0, h_shape[b]}, 32'd1);
                    end
                end
            end
        join
        chk("held_first_start", h_first[0], k + 1);
        chk("held_gap01", h_first[1] - h_first[0], NB*10*B + 3);
        chk("held_gap12", h_first[2] - h_first[1], NB*10*B + 3);
        tick(); tick();
        chk("held_done_cnt", done_cnt_a - dc, 3);
        chk("held_idle", {31'b0, busy_a}, 32'd0);

        // Reset during the start bit of byte 3.
        tick();
        drive(0, 1'b1, vec[0].c1, vec[0].c2);
        k = cyc + 1;
        tick();
        drive(0, 1'b0, vec[0].c1, vec[0].c2);
        n = 0;
        while (cyc < k + 30*B + 2 && n < 400) begin tick(); n++; end
        chk("midrst_pre_tx", {31'b0, tx_a}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_tx",   {31'b0, tx_a},   32'd1);
        chk("midrst_busy", {31'b0, busy_a}, 32'd0);
        chk("midrst_done", {31'b0, done_a}, 32'd0);
        dc = done_cnt_a;
        tick(); tick();
        rst = 1'b0;
        txbad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_a !== 1'b1) txbad = 1'b1;
        end
        chk("midrst_tx_idle", {31'b0, txbad}, 32'd0);
        chk("midrst_no_done", done_cnt_a - dc, 0);
        run_vec(0, vec[0], 0, "after_rst");

        // 16-bit instance: full-width hi bytes.
        run_vec(1, mk(16'hFFFF, 16'h0000, 8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h00), 0, "w16");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/adc_frame_tx.md
# adc_frame_tx

Serializes one two-channel ADC sample pair into a fixed UART frame. It sits directly downstream of the two-channel conversion sequencer and its channel-1/channel-2 holding registers. On a start pulse it latches both words, then emits a header byte and four data bytes as 8N1 serial on `tx_o`. A one-cycle `done_o` pulse marks the end of each frame, so the sequencer can be re-triggered.

## Interface
- `DATA_W`, default 12: ADC word width. Legal range is 9..16.
- `BAUD_DIV`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: frame request. Sampled only when idle; driven by the sequencer's end-of-sequence edge.
- `ch1_i` input DATA_W: channel-1 held sample.
- `ch2_i` input DATA_W: channel-2 held sample.
- `tx_o` output 1: UART serial line, idle high.
- `busy_o` output 1: high from the accept edge until `done_o` is asserted.
- `done_o` output 1: one-cycle pulse when the final stop bit completes.
- `ovr_o` output 1: one-cycle pulse when `start_i` is high while `busy_o` is high.

## Operation
- Reset values: `tx_o`=1, `busy_o`=0, `done_o`=0, `ovr_o`=0; FSM state IDLE; byte index 0; latched words 0.
- **Accept:** in IDLE, `start_i`=1 at a clock edge causes, on that same edge:
  - `ch1_i` and `ch2_i` are latched;
  - byte index is set to 0;
  - the FSM moves to SEND and `busy_o` rises.
- **Frame order:**
  - byte 0: header 0xA5;
  - byte 1: `ch1_hi`; byte 2: `ch1_lo`;
  - byte 3: `ch2_hi`; byte 4: `ch2_lo`.
- **Width rule:** `lo` = `ch[7:0]`. `hi` = `ch[DATA_W-1:8]` zero-extended to 8 bits.
- **Byte format:** 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each bit lasting exactly `BAUD_DIV` cycles.
- **FSM states:**
  - IDLE → SEND on `start_i`.
  - SEND presents the current byte to the serializer with valid held high. On the accepting edge the index increments.
  - After the last byte is accepted, SEND → DRAIN.
  - DRAIN waits for the serializer to report ready (last stop bit complete), then → DONE.
  - DONE asserts `done_o` for one cycle, drops `busy_o`, → IDLE.
- **Bytes are back-to-back:** the next start bit follows the previous stop bit with no idle cycle.
- **`start_i` while busy:** ignored, latched data is unaffected, and `ovr_o` pulses for that cycle. `start_i` in the DONE cycle is also ignored and raises `ovr_o`.
- **`start_i` held high:** a new frame is accepted on the first IDLE cycle after DONE.
- **Reset mid-frame:**
  - `tx_o` returns to 1 asynchronously;
  - the partial frame is discarded and `done_o` is not pulsed.
- Inputs `ch1_i`/`ch2_i` may change freely after the accept edge.

## Timing
- Accept edge k: `busy_o`=1 after k. The `tx_o` start bit of byte 0 begins after edge k+1.
- Frame duration is `5*10*BAUD_DIV` cycles from the first start-bit edge to the end of the last stop bit.
- `done_o` is high during the cycle after DRAIN sees ready, i.e. `50*BAUD_DIV+2` cycles after edge k.
- The earliest next accept is the edge following the `done_o` cycle.

## Configuration
- `ADC_FRAME_CHECKSUM_EN` defined:
  - a sixth byte is appended, equal to the XOR of bytes 0..4;
  - frame length becomes `60*BAUD_DIV`, and `done_o` shifts accordingly.
- Undefined: 5-byte frame and no checksum logic.

## Structure
- **Shared package/include `adc_tx_pkg`:** header constant 0xA5, frame byte count (5 / 6), FSM state encodings (IDLE, SEND, DRAIN, DONE), UART frame bit count 10.
- **Sub-module `uart_tx_byte`** (parameter `BAUD_DIV`):
  - ports `clk_i`, `rst_i`, `data_i[7:0]`, `valid_i`, `ready_o`, `tx_o`;
  - accepts a byte when `valid_i && ready_o`, with the start bit beginning the next cycle;
  - `ready_o` returns high `10*BAUD_DIV` cycles after acceptance.
- The top level holds the FSM, byte index, latched words, byte mux and optional checksum accumulator.

## Test plan
- `BAUD_DIV`=4, `ch1`=0xABC, `ch2`=0x123, one start pulse:
  - decoded bytes are A5 0A BC 01 23;
  - `done_o` pulses once, 202 cycles after accept;
  - `busy_o` stays high throughout.
- Same stimulus with `ADC_FRAME_CHECKSUM_EN`: bytes A5 0A BC 01 23 31, and `done_o` 242 cycles after accept.
- Second `start_i` pulse during byte 2: `ovr_o` pulses one cycle, and the frame bytes are unchanged.
- `start_i` held high for 3 frames with inputs changing each frame: three contiguous frames, each carrying the data present at its own accept edge.
- Assert `rst_i` mid byte 3: `tx_o`=1 immediately, `busy_o`=0, no `done_o`. The next start sends a complete, correct frame.
- `DATA_W`=16, `ch1`=0xFFFF, `ch2`=0x0000: bytes A5 FF FF 00 00, and `tx_o` bit period is exactly `BAUD_DIV` cycles.
